// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight, feeds decode via a 1-entry slot.
// Optional stall counter output guarded by `FETCH_STALL_COUNTER_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [3:0]            pc_upper,
  input  logic                  redirect_valid,
  input  logic [2:0]            PCSource,
  input  logic [ADDR_WIDTH-1:0] resolve_pc,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] jumpAddr,
  input  logic [ADDR_WIDTH-1:0] targetReg,
  input  logic [ADDR_WIDTH-1:0] branchAddr
`ifdef FETCH_STALL_COUNTER_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [31:0]           inst_q, inst_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [ADDR_WIDTH-1:0] seq_pc, target_raw, redirect_target;

  always_comb begin
    seq_pc = resolve_pc + ADDR_WIDTH'(4);
    case (PCSource)
      3'd1:    target_raw = jumpAddr;
      3'd2:    target_raw = targetReg;
      3'd3:    target_raw = branch_taken ? (seq_pc + branchAddr) : seq_pc;
      default: target_raw = seq_pc;
    endcase
    redirect_target = {target_raw[ADDR_WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect while a response is still owed leaves us in DISCARD to swallow it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_req && imem_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid)         state_d = ST_FETCH;
        else if (redirect_valid) state_d = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (imem_rvalid) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    if (reset && state_q == ST_FETCH) begin
      imem_req = !redirect_valid && (!inst_valid_q || inst_ready);
    end
  end

  always_comb begin
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    pc_out_d     = pc_out_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    if (inst_valid_q && inst_ready) inst_valid_d = 1'b0;
    if (state_q == ST_FETCH && imem_req && imem_ready) fetch_pc_d = pc_q;
    if (state_q == ST_WAIT && imem_rvalid && !redirect_valid) begin
      inst_d       = imem_rdata;
      pc_out_d     = fetch_pc_q;
      inst_valid_d = 1'b1;
      pc_d         = fetch_pc_q + ADDR_WIDTH'(4);
    end
    if (redirect_valid) begin
      pc_d         = redirect_target;
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      fetch_pc_q   <= '0;
      pc_out_q     <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      pc_out_q     <= pc_out_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst_valid  = inst_valid_q;
  assign instruction = inst_q;
  assign pc_out      = pc_out_q;
  assign pc_upper    = pc_out_q[ADDR_WIDTH-1 -: 4];

`ifdef FETCH_STALL_COUNTER_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!inst_valid_q && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: variable-latency memory, directed scenarios and a randomized run against a fetch-stream model.
module tb_inst_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [3:0]  pc_upper;
  logic        redirect_valid;
  logic [2:0]  PCSource;
  logic [31:0] resolve_pc;
  logic        branch_taken;
  logic [31:0] jumpAddr;
  logic [31:0] targetReg;
  logic [31:0] branchAddr;
`ifdef FETCH_STALL_COUNTER_EN
  logic [31:0] stall_count;
  logic [31:0] m_stall, e_stall, s_stall;
`endif

  inst_fetch_unit #(.RESET_PC(RST_PC), .ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .pc_out(pc_out), .pc_upper(pc_upper),
    .redirect_valid(redirect_valid), .PCSource(PCSource), .resolve_pc(resolve_pc),
    .branch_taken(branch_taken), .jumpAddr(jumpAddr), .targetReg(targetReg),
    .branchAddr(branchAddr)
`ifdef FETCH_STALL_COUNTER_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int lat   = 1;

  // memory model
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  // fetch-stream model: next fetch PC, owed response, output slot
  logic [31:0] m_fetch, m_raddr, m_ins, m_pc;
  logic        m_out, m_stale, m_valid;

  logic        e_req, e_valid;
  logic [31:0] e_addr, e_ins, e_pc;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_ins, s_pc;
  logic [3:0]  s_upper;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] tgt(input logic [2:0] src, input logic [31:0] rpc,
                                      input logic taken, input logic [31:0] ja,
                                      input logic [31:0] tr, input logic [31:0] ba);
    logic [31:0] t;
    if (src == 3'd1)      t = ja;
    else if (src == 3'd2) t = tr;
    else if (src == 3'd3) t = taken ? rpc + 32'd4 + ba : rpc + 32'd4;
    else                  t = rpc + 32'd4;
    return t & 32'hFFFF_FFFC;
  endfunction

  task automatic model_reset();
    m_fetch = RST_PC; m_raddr = '0; m_ins = '0; m_pc = '0;
    m_out = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
`ifdef FETCH_STALL_COUNTER_EN
    m_stall = '0;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect_valid = 1'b0; imem_rvalid = 1'b0; branch_taken = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // One clock: drive memory outputs, predict, sample at negedge, advance model after posedge.
  task automatic step();
    logic acc;
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
    e_req   = reset && !m_out && !redirect_valid && (!m_valid || inst_ready);
    e_addr  = m_fetch;
    e_valid = m_valid;
    e_ins   = m_ins;
    e_pc    = m_pc;
`ifdef FETCH_STALL_COUNTER_EN
    e_stall = m_stall;
`endif
    @(negedge clock);
    s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid;
    s_ins = instruction; s_pc = pc_out; s_upper = pc_upper;
`ifdef FETCH_STALL_COUNTER_EN
    s_stall = stall_count;
`endif
    @(posedge clock);
    #1;
    if (reset) begin
      acc = s_req && imem_ready;
`ifdef FETCH_STALL_COUNTER_EN
      if (!e_valid && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
      if (mem_busy) begin
        if (mem_cnt == 0) mem_busy = 1'b0;
        else mem_cnt--;
      end
      if (acc) begin mem_busy = 1'b1; mem_cnt = lat - 1; mem_addr = s_addr; end
      if (m_valid && inst_ready) m_valid = 1'b0;
      if (imem_rvalid && m_out) begin
        m_out = 1'b0;
        if (!m_stale && !redirect_valid) begin
          m_valid = 1'b1; m_ins = mem_word(m_raddr); m_pc = m_raddr; m_fetch = m_raddr + 32'd4;
        end
      end
      if (redirect_valid) begin
        m_fetch = tgt(PCSource, resolve_pc, branch_taken, jumpAddr, targetReg, branchAddr);
        m_valid = 1'b0;
        if (m_out) m_stale = 1'b1;
      end
      if (acc) begin m_out = 1'b1; m_stale = 1'b0; m_raddr = m_fetch; end
    end
  endtask

  task automatic test_reset();
    inst_ready = 1'b1; imem_ready = 1'b1;
    #2;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", inst_valid); end
    total++; if (instruction !== 32'h0 || pc_out !== 32'h0) begin
      bad++; $display("FAIL rst_data instr=%h pc=%h exp=0/0", instruction, pc_out);
    end
`ifdef FETCH_STALL_COUNTER_EN
    total++; if (stall_count !== 32'h0) begin bad++; $display("FAIL rst_stall got=%0d exp=0", stall_count); end
`endif
    do_reset();
  endtask

  task automatic test_sequential();
    int nreq = 0;
    logic [31:0] addrs [3];
    lat = 1; inst_ready = 1'b1; imem_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step();
      total++; if (s_req !== e_req || (e_req && s_addr !== e_addr)) begin
        bad++; $display("FAIL seq_req c=%0d got=%0b/%h exp=%0b/%h", c, s_req, s_addr, e_req, e_addr);
      end
      total++; if (s_valid !== (c >= 2 && c % 2 == 0)) begin
        bad++; $display("FAIL seq_valid_pattern c=%0d got=%0b", c, s_valid);
      end
      if (s_valid) begin
        total++; if (s_ins !== e_ins || s_pc !== e_pc || s_upper !== 4'h0) begin
          bad++; $display("FAIL seq_data c=%0d got=%h/%h/%h exp=%h/%h/0", c, s_ins, s_pc, s_upper, e_ins, e_pc);
        end
      end
      if (s_req && imem_ready && nreq < 3) begin addrs[nreq] = s_addr; nreq++; end
    end
    total++; if (nreq != 3) begin bad++; $display("FAIL seq_nreq got=%0d exp=3", nreq); end
    for (int i = 0; i < nreq; i++) begin
      total++; if (addrs[i] !== RST_PC + 32'(4 * i)) begin
        bad++; $display("FAIL seq_addr i=%0d got=%h exp=%h", i, addrs[i], RST_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    lat = 1; inst_ready = 1'b0; imem_ready = 1'b1;
    do_reset();
    step();
    total++; if (s_req !== 1'b1 || s_addr !== RST_PC) begin
      bad++; $display("FAIL bp_first got=%0b/%h exp=1/%h", s_req, s_addr, RST_PC);
    end
    step();
    for (int c = 0; c < 4; c++) begin
      step();
      total++; if (s_req !== 1'b0 || s_valid !== 1'b1 || s_ins !== mem_word(RST_PC) || s_pc !== RST_PC) begin
        bad++; $display("FAIL bp_hold c=%0d req=%0b vld=%0b ins=%h pc=%h exp=0/1/%h/%h",
                        c, s_req, s_valid, s_ins, s_pc, mem_word(RST_PC), RST_PC);
      end
    end
    inst_ready = 1'b1;
    step();
    total++; if (s_req !== 1'b1 || s_addr !== RST_PC + 32'd4) begin
      bad++; $display("FAIL bp_release got=%0b/%h exp=1/%h", s_req, s_addr, RST_PC + 32'd4);
    end
  endtask

  task automatic test_jump_wait();
    logic got = 1'b0;
    lat = 3; inst_ready = 1'b1; imem_ready = 1'b1;
    do_reset();
    step();
    total++; if (s_req !== 1'b1 || s_addr !== RST_PC) begin
      bad++; $display("FAIL jmp_first got=%0b/%h exp=1/%h", s_req, s_addr, RST_PC);
    end
    redirect_valid = 1'b1; PCSource = 3'd1; jumpAddr = 32'h0040_0100;
    step();
    redirect_valid = 1'b0;
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL jmp_wait_req got=%0b exp=0", s_req); end
    for (int c = 0; c < 2; c++) begin
      step();
      total++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin
        bad++; $display("FAIL jmp_discard c=%0d req=%0b vld=%0b exp=0/0", c, s_req, s_valid);
      end
    end
    step();
    total++; if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0040_0100) begin
      bad++; $display("FAIL jmp_refetch vld=%0b req=%0b addr=%h exp=0/1/00400100", s_valid, s_req, s_addr);
    end
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (s_valid) got = 1'b1;
    end
    total++; if (!got || s_pc !== 32'h0040_0100 || s_ins !== mem_word(32'h0040_0100)) begin
      bad++; $display("FAIL jmp_deliver seen=%0b pc=%h ins=%h exp=1/00400100/%h", got, s_pc, s_ins, mem_word(32'h0040_0100));
    end
  endtask

  task automatic test_branch();
    for (int t = 0; t < 2; t++) begin
      lat = 1; inst_ready = 1'b1; imem_ready = 1'b1;
      do_reset();
      redirect_valid = 1'b1; PCSource = 3'd3; resolve_pc = 32'h0040_0010;
      branchAddr = 32'hFFFF_FFF0; branch_taken = (t == 1);
      step();
      redirect_valid = 1'b0; branch_taken = 1'b0;
      total++; if (s_req !== 1'b0) begin bad++; $display("FAIL br_gate t=%0d got=%0b exp=0", t, s_req); end
      step();
      total++; if (s_req !== 1'b1 || s_addr !== ((t == 1) ? 32'h0040_0004 : 32'h0040_0014)) begin
        bad++; $display("FAIL br_target t=%0d got=%0b/%h exp=1/%h", t, s_req, s_addr,
                        (t == 1) ? 32'h0040_0004 : 32'h0040_0014);
      end
    end
  endtask

  task automatic test_jr_wrap();
    lat = 1; inst_ready = 1'b1; imem_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1; PCSource = 3'd2; targetReg = 32'h0040_0203;
    step();
    redirect_valid = 1'b0;
    step();
    total++; if (s_req !== 1'b1 || s_addr !== 32'h0040_0200) begin
      bad++; $display("FAIL jr_align got=%0b/%h exp=1/00400200", s_req, s_addr);
    end
    redirect_valid = 1'b1; PCSource = 3'd1; jumpAddr = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    total++; if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_fetch vld=%0b req=%0b addr=%h exp=0/1/fffffffc", s_valid, s_req, s_addr);
    end
    step();
    step();
    total++; if (s_valid !== 1'b1 || s_pc !== 32'hFFFF_FFFC || s_upper !== 4'hF) begin
      bad++; $display("FAIL wrap_deliver vld=%0b pc=%h upper=%h exp=1/fffffffc/f", s_valid, s_pc, s_upper);
    end
    total++; if (s_req !== 1'b1 || s_addr !== 32'h0000_0000) begin
      bad++; $display("FAIL wrap_next got=%0b/%h exp=1/00000000", s_req, s_addr);
    end
  endtask

  task automatic test_async_reset();
    lat = 1; inst_ready = 1'b0; imem_ready = 1'b1;
    do_reset();
    repeat (3) step();
    inst_ready = 1'b1;
    #1;
    total++; if (inst_valid !== 1'b1 || imem_req !== 1'b1) begin
      bad++; $display("FAIL arst_pre vld=%0b req=%0b exp=1/1", inst_valid, imem_req);
    end
    #1 reset = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0 || imem_req !== 1'b0 || instruction !== 32'h0 || pc_out !== 32'h0) begin
      bad++; $display("FAIL arst_fetch vld=%0b req=%0b ins=%h pc=%h exp=0", inst_valid, imem_req, instruction, pc_out);
    end
    model_reset(); imem_rvalid = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    lat = 3;
    repeat (5) step();
    #1;
    total++; if (instruction !== mem_word(RST_PC) || inst_valid !== 1'b0) begin
      bad++; $display("FAIL arst_wait_pre ins=%h vld=%0b exp=%h/0", instruction, inst_valid, mem_word(RST_PC));
    end
    #1 reset = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0 || imem_req !== 1'b0 || instruction !== 32'h0 || pc_out !== 32'h0) begin
      bad++; $display("FAIL arst_wait vld=%0b req=%0b ins=%h pc=%h exp=0", inst_valid, imem_req, instruction, pc_out);
    end
    model_reset(); imem_rvalid = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    step();
    total++; if (s_req !== 1'b1 || s_addr !== RST_PC) begin
      bad++; $display("FAIL arst_restart got=%0b/%h exp=1/%h", s_req, s_addr, RST_PC);
    end
`ifdef FETCH_STALL_COUNTER_EN
    total++; if (s_stall !== 32'd0) begin bad++; $display("FAIL stall_zero got=%0d exp=0", s_stall); end
`endif
    for (int c = 0; c < 8; c++) begin
      step();
      total++; if (s_valid !== e_valid || (e_valid && s_pc !== e_pc)) begin
        bad++; $display("FAIL arst_follow c=%0d vld=%0b pc=%h exp=%0b/%h", c, s_valid, s_pc, e_valid, e_pc);
      end
`ifdef FETCH_STALL_COUNTER_EN
      total++; if (s_stall !== e_stall) begin bad++; $display("FAIL stall_count c=%0d got=%0d exp=%0d", c, s_stall, e_stall); end
`endif
    end
  endtask

  task automatic test_random();
    int delivered = 0;
    for (int r = 0; r < 4; r++) begin
      lat = $urandom_range(1, 4);
      do_reset();
      for (int c = 0; c < 300; c++) begin
        inst_ready     = ($urandom_range(0, 9) < 7);
        imem_ready     = ($urandom_range(0, 9) < 7);
        redirect_valid = ($urandom_range(0, 99) < 8);
        PCSource       = 3'($urandom_range(0, 3));
        resolve_pc     = $urandom;
        jumpAddr       = $urandom;
        targetReg      = $urandom;
        branchAddr     = $urandom;
        branch_taken   = 1'($urandom_range(0, 1));
        step();
        total++; if (s_req !== e_req) begin
          bad++; $display("FAIL rnd_req r=%0d c=%0d got=%0b exp=%0b", r, c, s_req, e_req);
        end
        if (e_req) begin
          total++; if (s_addr !== e_addr) begin
            bad++; $display("FAIL rnd_addr r=%0d c=%0d got=%h exp=%h", r, c, s_addr, e_addr);
          end
        end
        total++; if (s_valid !== e_valid) begin
          bad++; $display("FAIL rnd_valid r=%0d c=%0d got=%0b exp=%0b", r, c, s_valid, e_valid);
        end
        if (e_valid) begin
          delivered++;
          total++; if (s_ins !== e_ins || s_pc !== e_pc || s_upper !== e_pc[31:28]) begin
            bad++; $display("FAIL rnd_data r=%0d c=%0d got=%h/%h/%h exp=%h/%h", r, c, s_ins, s_pc, s_upper, e_ins, e_pc);
          end
        end
`ifdef FETCH_STALL_COUNTER_EN
        total++; if (s_stall !== e_stall) begin
          bad++; $display("FAIL rnd_stall r=%0d c=%0d got=%0d exp=%0d", r, c, s_stall, e_stall);
        end
`endif
      end
    end
    redirect_valid = 1'b0;
    total++; if (delivered < 50) begin bad++; $display("FAIL rnd_progress got=%0d exp>=50", delivered); end
  endtask

  initial begin
    reset = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; PCSource = '0; resolve_pc = '0;
    branch_taken = 1'b0; jumpAddr = '0; targetReg = '0; branchAddr = '0;
    model_reset();
    test_reset();
    test_sequential();
    test_backpressure();
    test_jump_wait();
    test_branch();
    test_jr_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage, directly upstream of inst_decoder.
- Holds the architectural PC and issues one instruction-memory request at a time over a valid/ready request channel with a variable-latency response.
- Presents the fetched instruction plus its PC to decode through a single-entry valid/ready output register.
- Applies redirects (jump, JR/JALR, branch) from the PCSource/jumpAddr/targetReg/branchAddr outputs of inst_decoder, and supplies the 4-bit PC nibble decode uses for jumpAddr.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset release; bits [1:0] must be 0.
ADDR_WIDTH, 32, width of PC and instruction addresses; only 32 is supported.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = in reset).
imem_req  out  1  request valid.
imem_addr  out  32  word-aligned fetch address.
imem_ready  in  1  memory accepts the request this cycle.
imem_rvalid  in  1  response valid.
imem_rdata  in  32  response instruction word.
inst_valid  out  1  output register holds an instruction.
inst_ready  in  1  decode consumes the instruction this cycle.
instruction  out  32  instruction to decode.
pc_out  out  32  PC of instruction.
pc_upper  out  4  pc_out[31:28]; drives decode PC input.
redirect_valid  in  1  one-cycle pulse, control transfer resolved.
PCSource  in  3  0 seq, 1 J/JAL, 2 JR/JALR, 3 branch.
resolve_pc  in  32  PC of the resolving control instruction.
branch_taken  in  1  branch condition result (PCSource==3 only).
jumpAddr  in  32  J/JAL target.
targetReg  in  32  JR/JALR target.
branchAddr  in  32  sign-extended word offset, already shifted left by 2.

Behaviour:
- Reset (reset==0, asynchronous):
  - pc_reg=RESET_PC; state=FETCH.
  - inst_valid=0, instruction=0, pc_out=0.
  - imem_req is forced to 0 while reset==0.
- States: FETCH, WAIT, DISCARD. At most one request is outstanding.
- FETCH:
  - imem_req = !redirect_valid && (!inst_valid || inst_ready); imem_addr = pc_reg.
  - On imem_req && imem_ready: fetch_pc<=pc_reg, go to WAIT.
  - imem_rvalid in FETCH is ignored.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: instruction<=imem_rdata, pc_out<=fetch_pc, inst_valid<=1, pc_reg<=fetch_pc+4, go to FETCH.
  - The output slot is guaranteed free, because the request was issued only when the slot was empty or draining.
- Output slot: inst_valid && inst_ready clears inst_valid at the edge unless it is reloaded that same edge. instruction and pc_out stay stable while inst_valid && !inst_ready.
- Redirect target, computed combinationally:
  - PCSource 1: jumpAddr.
  - PCSource 2: targetReg.
  - PCSource 3: taken gives resolve_pc+4+branchAddr; not taken gives resolve_pc+4.
  - PCSource 0: resolve_pc+4.
  - Bits [1:0] of the target are forced to 0. All additions are modulo 2^32 (0xFFFFFFFC+4 = 0).
- Redirect has priority over every other event in the same cycle:
  - pc_reg<=target; inst_valid<=0, flushing the slot even if inst_ready is high.
  - FETCH goes to FETCH, with imem_req gated to 0 that cycle.
  - WAIT with imem_rvalid in the same cycle: the response is dropped, go to FETCH.
  - WAIT without imem_rvalid goes to DISCARD.
  - DISCARD stays in DISCARD; pc_reg is overwritten by the newer target.
- DISCARD: imem_req=0. On imem_rvalid the data is dropped, pc_reg is unchanged, go to FETCH.
- Throughput: at most one instruction per 2 cycles with 1-cycle memory latency.
- Reset asserted mid-operation: any in-flight response is abandoned, and the memory is reset by the same signal.

Optional Feature:
FETCH_STALL_COUNTER_EN:
- Defined: adds output stall_count [31:0].
  - Reset to 0.
  - Increments every cycle with reset==1 and inst_valid==0.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Sequential fetch: RESET_PC=0x00400000, 1-cycle memory latency, inst_ready=1 -> imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive requests; inst_valid high every 2nd cycle; pc_out matches each address; pc_upper=0x0.
- Backpressure: hold inst_ready=0 after the first instruction -> no further imem_req; instruction and pc_out stable; raise inst_ready -> next request at 0x00400004 in the same cycle.
- Jump during WAIT: memory latency 3, redirect_valid with PCSource=1 and jumpAddr=0x00400100 -> state DISCARD; stale response dropped and never shown; next imem_addr=0x00400100.
- Branch: resolve_pc=0x00400010, branchAddr=0xFFFFFFF0, PCSource=3 -> taken gives next address 0x00400004; not taken gives 0x00400014.
- JR misaligned/wrap: targetReg=0x00400203 -> imem_addr 0x00400200. Fetch at 0xFFFFFFFC -> next address 0x00000000.
- Async reset in WAIT: drive reset=0 mid-cycle -> inst_valid, imem_req, instruction and pc_out go to 0 without a clock edge; after release the first request is at RESET_PC. With FETCH_STALL_COUNTER_EN, stall_count reads 0 then counts the empty cycles.
